// File: rtl/cpu_pkg.sv
// Shared datapath types for the result buffer: word widths, read-state encoding,
// the stored entry layout and the per-result flag helper.
package cpu_pkg;

    localparam int WORD_W  = 32;
    localparam int DWORD_W = 64;

    typedef enum logic [0:0] {
        S_LO = 1'b0,
        S_HI = 1'b1
    } zrb_state_t;

    typedef struct packed {
        logic [DWORD_W-1:0] data;
        logic               wide;
        logic               z;
        logic               n;
    } zrb_entry_t;

    // {z, n}: zero and sign over 64 bits for wide results, low 32 bits otherwise
    function automatic logic [1:0] zrb_flags(input logic [DWORD_W-1:0] data, input logic wide);
        logic z;
        logic n;
        z = wide ? (data == '0) : (data[WORD_W-1:0] == '0);
        n = wide ? data[DWORD_W-1] : data[WORD_W-1];
        return {z, n};
    endfunction

endpackage

// File: rtl/zrb_fifo_mem.sv
// Result-buffer storage: DEPTH x W register file, one synchronous write port,
// asynchronous read at the read pointer. Contents are not reset.
module zrb_fifo_mem #(
    parameter int DEPTH = 2,
    parameter int AW    = 1,
    parameter int W     = 65
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_ptr,
    input  logic [W-1:0]  wr_word,
    input  logic [AW-1:0] rd_ptr,
    output logic [W-1:0]  rd_word
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= wr_word;
    end

    assign rd_word = mem[rd_ptr];

endmodule

// File: rtl/z_result_buffer.sv
// Result FIFO between ALU completion and bus write-back; emits lo then hi word
// for wide results. Define ZRB_FLAGS_EN to store and drive per-entry z/n flags.
module z_result_buffer
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = 1
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DWORD_W-1:0] in_data,
    input  logic               in_wide,
    output logic               out_valid,
    output logic [WORD_W-1:0]  out_data,
    output logic               out_hi,
    output logic               out_last,
    input  logic               out_take,
    output logic               flag_z,
    output logic               flag_n
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

`ifdef ZRB_FLAGS_EN
    localparam int MW = $bits(zrb_entry_t);
`else
    localparam int MW = DWORD_W + 1;
`endif

    logic [AW:0]        count;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    zrb_state_t         state;
    logic [MW-1:0]      wr_word;
    logic [MW-1:0]      rd_word;
    logic [DWORD_W-1:0] head_data;
    logic               head_wide;
    logic               push;
    logic               take;
    logic               pop;

`ifdef ZRB_FLAGS_EN
    zrb_entry_t wr_entry;
    zrb_entry_t head;
    logic [1:0] in_flags;

    assign in_flags = zrb_flags(in_data, in_wide);
    always_comb begin
        wr_entry      = '0;
        wr_entry.data = in_data;
        wr_entry.wide = in_wide;
        wr_entry.z    = in_flags[1];
        wr_entry.n    = in_flags[0];
    end
    assign wr_word   = wr_entry;
    assign head      = rd_word;
    assign head_data = head.data;
    assign head_wide = head.wide;
    assign flag_z    = out_valid & head.z;
    assign flag_n    = out_valid & head.n;
`else
    assign wr_word   = {in_data, in_wide};
    assign head_data = rd_word[MW-1:1];
    assign head_wide = rd_word[0];
    assign flag_z    = 1'b0;
    assign flag_n    = 1'b0;
`endif

    zrb_fifo_mem #(.DEPTH(DEPTH), .AW(AW), .W(MW)) u_mem (
        .clk     (clk),
        .we      (push),
        .wr_ptr  (wr_ptr),
        .wr_word (wr_word),
        .rd_ptr  (rd_ptr),
        .rd_word (rd_word)
    );

    // Readiness comes from registered count only, so a pop never opens a slot same-cycle
    assign in_ready  = (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign take      = out_take && out_valid;
    assign pop       = take && (state == S_HI || !head_wide);

    assign out_data = !out_valid     ? '0 :
                      (state == S_HI) ? head_data[DWORD_W-1:WORD_W] : head_data[WORD_W-1:0];
    assign out_hi   = out_valid && (state == S_HI);
    assign out_last = out_valid && (state == S_HI || !head_wide);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= S_LO;
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            state  <= S_LO;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (take) state <= (state == S_LO && head_wide) ? S_HI : S_LO;
        end
    end

endmodule

// File: tb/tb_z_result_buffer.sv
// Self-checking bench for z_result_buffer: directed scenarios then random traffic,
// against a word-queue reference model.
module tb_z_result_buffer;

    localparam int DEPTH = 2;
    localparam int AW    = 1;

    logic        clk = 1'b0;
    logic        clr;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_wide;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_hi;
    logic        out_last;
    logic        out_take;
    logic        flag_z;
    logic        flag_n;

    int n_cmp = 0;
    int n_err = 0;

    z_result_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_wide   (in_wide),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_hi    (out_hi),
        .out_last  (out_last),
        .out_take  (out_take),
        .flag_z    (flag_z),
        .flag_n    (flag_n)
    );

    always #5 clk = ~clk;

    // Model: the bus-visible word stream still owed; an entry is resident until its last word leaves.
    typedef struct {
        logic [31:0] w;
        logic        hi;
        logic        last;
        logic        z;
        logic        n;
    } wrd_t;

    wrd_t q[$];

    function automatic int entries();
        int e = 0;
        foreach (q[i]) if (q[i].last) e++;
        return e;
    endfunction

    function automatic void model_push(input logic [63:0] d, input logic w);
        wrd_t a;
        logic z = 1'b0;
        logic n = 1'b0;
`ifdef ZRB_FLAGS_EN
        z = w ? (d == 64'd0) : (d[31:0] == 32'd0);
        n = w ? d[63] : d[31];
`endif
        a.w = d[31:0]; a.hi = 1'b0; a.last = !w; a.z = z; a.n = n;
        q.push_back(a);
        if (w) begin
            a.w = d[63:32]; a.hi = 1'b1; a.last = 1'b1;
            q.push_back(a);
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic        ev = (q.size() != 0);
        logic [31:0] ed = ev ? q[0].w : 32'd0;
        chk({tag, "/out_valid"}, 64'(out_valid), 64'(ev));
        chk({tag, "/in_ready"},  64'(in_ready),  64'(entries() < DEPTH));
        chk({tag, "/out_data"},  64'(out_data),  64'(ed));
        chk({tag, "/out_hi"},    64'(out_hi),    64'(ev ? q[0].hi : 1'b0));
        chk({tag, "/out_last"},  64'(out_last),  64'(ev ? q[0].last : 1'b0));
        chk({tag, "/flag_z"},    64'(flag_z),    64'(ev ? q[0].z : 1'b0));
        chk({tag, "/flag_n"},    64'(flag_n),    64'(ev ? q[0].n : 1'b0));
    endtask

    // One clock: drive, check pre-edge outputs, advance model across the edge.
    task automatic step(input string tag, input logic v, input logic [63:0] d, input logic w,
                        input logic tk, input logic fl);
        logic can_push;
        logic has_word;
        in_valid = v; in_data = d; in_wide = w; out_take = tk; flush = fl;
        #1;
        check_outputs(tag);
        can_push = v && (entries() < DEPTH);
        has_word = (q.size() != 0);
        @(posedge clk);
        if (fl) q.delete();
        else begin
            if (tk && has_word) void'(q.pop_front());
            if (can_push) model_push(d, w);
        end
        #1;
    endtask

    initial begin
        logic [63:0] d;
        clr = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_wide = 1'b0; out_take = 1'b0;
        #12;
        check_outputs("reset");
        clr = 1'b0;
        @(posedge clk); #1;

        // narrow push then take
        step("nar_push", 1, 64'h0000_0000_0000_0010, 0, 0, 0);
        chk("nar_data", 64'(out_data), 64'h10);
        chk("nar_last", 64'(out_last), 64'd1);
        step("nar_take", 0, 0, 0, 1, 0);
        chk("nar_empty", 64'(out_valid), 64'd0);

        // wide push, two words, one pop
        step("wide_push", 1, 64'hFFFF_FFFF_0000_0001, 1, 0, 0);
        chk("wide_lo_last", 64'(out_last), 64'd0);
        step("wide_lo", 0, 0, 0, 1, 0);
        chk("wide_hi_data", 64'(out_data), 64'hFFFF_FFFF);
        chk("wide_hi_flag", 64'(out_hi), 64'd1);
        step("wide_hi", 0, 0, 0, 1, 0);
        chk("wide_done", 64'(out_valid), 64'd0);

        // fill, overflow ignored, drain
        step("fill_a", 1, 64'hA, 0, 0, 0);
        step("fill_b", 1, 64'hB, 0, 0, 0);
        chk("full_ready", 64'(in_ready), 64'd0);
        step("fill_c", 1, 64'hC, 0, 0, 0);
        step("drain_a", 0, 0, 0, 1, 0);
        step("drain_b", 0, 0, 0, 1, 0);
        step("drain_e", 0, 0, 0, 0, 0);

        // steady stream, count stays 1 and pointers wrap
        step("strm_0", 1, 64'h100, 0, 0, 0);
        for (int i = 1; i <= 8; i++) step("strm", 1, 64'(32'h100 + i), 0, 1, 0);
        step("strm_end", 0, 0, 0, 1, 0);

        // flush in S_HI with a concurrent push
        step("fl_wide", 1, 64'h1234_5678_9ABC_DEF0, 1, 0, 0);
        step("fl_lo", 0, 0, 0, 1, 0);
        step("fl_do", 1, 64'h5, 0, 1, 1);
        chk("fl_valid", 64'(out_valid), 64'd0);
        step("fl_after", 0, 0, 0, 0, 0);

        // zero result flags
        step("zero_push", 1, 64'h0, 0, 0, 0);
        step("zero_take", 0, 0, 0, 1, 0);

        // async reset between edges with two entries held
        step("ar_a", 1, 64'h11, 0, 0, 0);
        step("ar_b", 1, 64'h8000_0022, 0, 0, 0);
        in_valid = 1'b0; out_take = 1'b0;
        #2 clr = 1'b1;
        #1;
        q.delete();
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_ready", 64'(in_ready), 64'd1);
        check_outputs("ar_now");
        #1 clr = 1'b0;
        @(posedge clk); #1;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            d = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) d = '0;
            if ($urandom_range(0, 7) == 0) d[31:0] = '0;
            step("rand", 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/z_result_buffer.md
Name: z_result_buffer

Overview:
- Downstream of the shifter/rotator and ALU datapath: captures each completed result (32-bit narrow, or 64-bit wide for MUL/DIV) into a small FIFO.
- Presents results to the internal bus one 32-bit word at a time: lo word first, then hi word for wide results.
- Decouples ALU completion from bus write-back scheduling.
- Also delivers per-result condition flags.

Parameters:
- DEPTH, 2, number of result entries; power of two, 2..8.
- AW, 1, pointer width = log2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- flush  in  1  synchronous discard of all entries.
- in_valid  in  1  upstream result available.
- in_ready  out  1  buffer can accept (= !full, registered-state only).
- in_data  in  64  result; narrow ops use [31:0], [63:32] ignored.
- in_wide  in  1  1 = 64-bit result (hi/lo pair).
- out_valid  out  1  head word available to bus.
- out_data  out  32  head word.
- out_hi  out  1  0 = lo word, 1 = hi word.
- out_last  out  1  current word is last of its entry.
- out_take  in  1  bus consumes current word this cycle.
- flag_z  out  1  head entry result zero (full 64 bits if wide, else [31:0]).
- flag_n  out  1  head entry sign (bit 63 if wide, else bit 31).

Behaviour:
- Clocking/reset: one clock clk; reset clr is asynchronous and active-high.
- clr asserted: count=0, wr_ptr=rd_ptr=0, read state=S_LO, and all outputs 0 (in_ready=1 after reset). Storage contents are don't-care.
- Push: occurs when in_valid && in_ready && !flush. Stores {in_data, in_wide, z, n} at wr_ptr. wr_ptr increments mod DEPTH.
- Flags are computed at push from in_data/in_wide and stored with the entry.
- Latency: a pushed entry is first visible on out_* the cycle after the push edge. There is no bypass.
- Read FSM, per head entry:
  - S_LO: out_data=lo, out_hi=0, out_last=!wide.
  - S_HI: out_data=hi, out_hi=1, out_last=1.
  - S_LO + out_take + narrow: pop, stay S_LO.
  - S_LO + out_take + wide: go S_HI, no pop.
  - S_HI + out_take: pop, go S_LO.
- Pop: rd_ptr increments mod DEPTH, count decrements.
- out_valid = (count != 0).
- When !out_valid: out_data, out_hi, out_last and flags are driven 0, and out_take is ignored.
- Simultaneous push and pop (non-full, non-empty): count unchanged, pointers both advance.
- Full: in_ready=0, so in_valid is ignored. in_ready does not depend combinationally on out_take; a pop while full frees the slot for the next cycle.
- Empty with push: out_valid rises the next cycle.
- Pointer wrap-around: natural modulo; full/empty derived from count (AW+1 bits), not from pointer equality.
- flush: the next edge sets count=0, pointers=0, state=S_LO. It overrides a concurrent push and pop; the push is dropped even though in_ready was 1.
- flush mid-wide-readout (state S_HI): returns to S_LO, and the hi word is discarded.
- clr mid-operation: immediate asynchronous return to reset values.

Optional Feature:
- Macro: ZRB_FLAGS_EN.
- Defined: flag_z and flag_n are stored per entry and driven as above.
- Undefined: no flag storage is built, and flag_z and flag_n are tied 0. The ports remain present.

Decomposition:
- Shared package (cpu_pkg):
  - WORD_W=32, DWORD_W=64.
  - Read-state encoding, zrb_state_t {S_LO, S_HI}.
  - Entry struct/typedef: data[63:0], wide, z, n.
- One natural sub-module, zrb_fifo_mem: DEPTH x entry register file with write port and async read at rd_ptr.
- FSM, counters and flag logic stay in the top level.

Test Plan:
- Narrow push: in_data=0x0000_0000_0000_0010, wide=0, take on the next cycle -> out_data=0x00000010, out_hi=0, out_last=1, flag_z=0, flag_n=0; out_valid=0 afterwards.
- Wide push: in_data=0xFFFF_FFFF_0000_0001, wide=1 -> first word 0x00000001 (out_hi=0, out_last=0), then 0xFFFFFFFF (out_hi=1, out_last=1), flag_n=1; exactly one pop.
- Fill DEPTH=2 with 0xA, 0xB, no takes -> in_ready=0; third push 0xC ignored; drain yields 0xA, 0xB only.
- Steady stream with concurrent push and take every cycle over 8 results, pointers wrapping -> in-order output, count constant at 1, no loss.
- flush while in S_HI of a wide entry with a concurrent push of 0x5 -> next cycle out_valid=0, state S_LO; the push is dropped.
- Async reset: assert clr between clock edges with 2 entries held -> out_valid=0 and in_ready=1 immediately. With the macro undefined, push 0 -> flag_z stays 0.
